// File: rtl/uart_pkg.sv
// Shared constants for the parameterised UART: TX/RX state encodings and parity selectors.
package uart_pkg;

    localparam int unsigned PARITY_EVEN    = 0;
    localparam int unsigned PARITY_ODD_SEL = 1;

    localparam int unsigned ST_W = 3;

    localparam logic [2:0] TX_IDLE   = 3'd0;
    localparam logic [2:0] TX_START  = 3'd1;
    localparam logic [2:0] TX_DATA   = 3'd2;
    localparam logic [2:0] TX_PARITY = 3'd3;
    localparam logic [2:0] TX_STOP   = 3'd4;

    localparam logic [2:0] RX_IDLE      = 3'd0;
    localparam logic [2:0] RX_START     = 3'd1;
    localparam logic [2:0] RX_DATA      = 3'd2;
    localparam logic [2:0] RX_PARITY    = 3'd3;
    localparam logic [2:0] RX_STOP      = 3'd4;
    localparam logic [2:0] RX_WAIT_HIGH = 3'd5;

endpackage

// File: rtl/uart_param_rx.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling, frame/parity error reporting.
// Parity checking (and the PARITY_ODD parameter) exist only when UART_PARITY_EN is defined.
module uart_param_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned BAUD_DIV = 16
`ifdef UART_PARITY_EN
    ,
    parameter int unsigned PARITY_ODD = 0
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_done,
    output logic              rx_frame_err,
    output logic              rx_parity_err
);

    localparam int unsigned CNT_W = $clog2(BAUD_DIV + 1);
    localparam int unsigned BIT_W = 4;
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(BAUD_DIV / 2);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BAUD_DIV);
`ifdef UART_PARITY_EN
    localparam logic PAR_ODD_L = (PARITY_ODD == PARITY_ODD_SEL);
`endif

    logic              rx_meta_q, rx_sync_q, rx_prev_q;
    logic [ST_W-1:0]   state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              done_q, done_d;
    logic              ferr_q, ferr_d;
`ifdef UART_PARITY_EN
    logic              perr_pend_q, perr_pend_d;
    logic              perr_q, perr_d;
`endif

    // Synchronizer plus one history flop for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // cnt_q counts cycles since the last sample point (or since the start edge).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = ferr_q;
`ifdef UART_PARITY_EN
        perr_pend_d = perr_pend_q;
        perr_d      = perr_q;
`endif
        case (state_q)
            RX_IDLE: begin
                cnt_d = CNT_W'(1);
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d   = CNT_W'(1);
                    bit_d   = '0;
                    state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_CNT) begin
                    cnt_d   = CNT_W'(1);
                    shift_d = {rx_sync_q, shift_q[DATA_W-1:1]};
                    if (bit_q == BIT_W'(DATA_W - 1)) begin
`ifdef UART_PARITY_EN
                        state_d = RX_PARITY;
`else
                        state_d = RX_STOP;
`endif
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
                if (cnt_q == FULL_CNT) begin
                    cnt_d       = CNT_W'(1);
                    perr_pend_d = (^shift_q) ^ rx_sync_q ^ PAR_ODD_L;
                    state_d     = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (cnt_q == FULL_CNT) begin
                    data_d  = shift_q;
                    done_d  = 1'b1;
                    ferr_d  = ~rx_sync_q;
`ifdef UART_PARITY_EN
                    perr_d  = perr_pend_q;
`endif
                    state_d = rx_sync_q ? RX_IDLE : RX_WAIT_HIGH;
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_sync_q) begin
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_PARITY_EN
            perr_pend_q <= 1'b0;
            perr_q      <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
`ifdef UART_PARITY_EN
            perr_pend_q <= perr_pend_d;
            perr_q      <= perr_d;
`endif
        end
    end

    assign rx_data      = data_q;
    assign rx_done      = done_q;
    assign rx_frame_err = ferr_q;
`ifdef UART_PARITY_EN
    assign rx_parity_err = perr_q;
`else
    assign rx_parity_err = 1'b0;
`endif

endmodule

// File: rtl/uart_param_core.sv
// Parameterised full-duplex UART: inline transmitter FSM plus uart_param_rx receiver.
// Optional parity bit is compiled in by defining UART_PARITY_EN.
module uart_param_core
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned BAUD_DIV   = 16,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_start,
    output logic              tx,
    output logic              tx_busy,
    output logic              tx_done,
    input  logic              rx,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_done,
    output logic              rx_frame_err,
    output logic              rx_parity_err
);

    localparam int unsigned CNT_W = $clog2(BAUD_DIV);
    localparam int unsigned BIT_W = 4;
`ifdef UART_PARITY_EN
    localparam logic PAR_ODD_L = (PARITY_ODD == PARITY_ODD_SEL);
`endif

    // Reject parameter sets the datapath is not sized for.
    if (DATA_W < 5 || DATA_W > 9 || BAUD_DIV < 4 || (BAUD_DIV % 2) != 0 ||
        STOP_BITS < 1 || STOP_BITS > 2 ||
        (PARITY_ODD != PARITY_EVEN && PARITY_ODD != PARITY_ODD_SEL)) begin : g_bad_cfg
        $error("uart_param_core: illegal parameter combination");
    end

    logic [ST_W-1:0]   tx_state_q, tx_state_d;
    logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic [BIT_W-1:0]  tx_bit_q, tx_bit_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic              tx_q, tx_d;
    logic              tx_busy_q, tx_busy_d;
    logic              tx_done_q, tx_done_d;
    logic              tx_baud_end;
`ifdef UART_PARITY_EN
    logic              tx_par_q, tx_par_d;
`endif

    assign tx_baud_end = (tx_cnt_q == CNT_W'(BAUD_DIV - 1));

    // tx_q always holds the level of the bit currently on the line.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        tx_busy_d  = tx_busy_q;
        tx_done_d  = 1'b0;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        if (tx_state_q != TX_IDLE) begin
            tx_cnt_d = tx_baud_end ? '0 : tx_cnt_q + CNT_W'(1);
        end
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_start) begin
                    tx_state_d = TX_START;
                    tx_cnt_d   = '0;
                    tx_shift_d = tx_data;
                    tx_d       = 1'b0;
                    tx_busy_d  = 1'b1;
`ifdef UART_PARITY_EN
                    tx_par_d   = (^tx_data) ^ PAR_ODD_L;
`endif
                end
            end
            TX_START: begin
                if (tx_baud_end) begin
                    tx_state_d = TX_DATA;
                    tx_bit_d   = '0;
                    tx_d       = tx_shift_q[0];
                end
            end
            TX_DATA: begin
                if (tx_baud_end) begin
                    if (tx_bit_q == BIT_W'(DATA_W - 1)) begin
`ifdef UART_PARITY_EN
                        tx_state_d = TX_PARITY;
                        tx_d       = tx_par_q;
`else
                        tx_state_d = TX_STOP;
                        tx_bit_d   = '0;
                        tx_d       = 1'b1;
`endif
                    end else begin
                        tx_bit_d   = tx_bit_q + BIT_W'(1);
                        tx_shift_d = tx_shift_q >> 1;
                        tx_d       = tx_shift_q[1];
                    end
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: begin
                if (tx_baud_end) begin
                    tx_state_d = TX_STOP;
                    tx_bit_d   = '0;
                    tx_d       = 1'b1;
                end
            end
`endif
            TX_STOP: begin
                if (tx_baud_end) begin
                    if (tx_bit_q == BIT_W'(STOP_BITS - 1)) begin
                        tx_state_d = TX_IDLE;
                        tx_busy_d  = 1'b0;
                        tx_done_d  = 1'b1;
                    end else begin
                        tx_bit_d = tx_bit_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                tx_d       = 1'b1;
                tx_busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            tx_busy_q  <= tx_busy_d;
            tx_done_q  <= tx_done_d;
`ifdef UART_PARITY_EN
            tx_par_q   <= tx_par_d;
`endif
        end
    end

    assign tx      = tx_q;
    assign tx_busy = tx_busy_q;
    assign tx_done = tx_done_q;

    uart_param_rx #(
        .DATA_W     (DATA_W),
        .BAUD_DIV   (BAUD_DIV)
`ifdef UART_PARITY_EN
        ,
        .PARITY_ODD (PARITY_ODD)
`endif
    ) u_rx (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx),
        .rx_data       (rx_data),
        .rx_done       (rx_done),
        .rx_frame_err  (rx_frame_err),
        .rx_parity_err (rx_parity_err)
    );

endmodule
